// File: rtl/tdp_ram_bw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_pkg
// Description : Shared constants, state encoding and helpers for the
//               byte-write true dual-port RAM family.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    // Same-port read-during-write behaviour
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Winner of overlapping lanes when both ports write the same word
    localparam int PRIO_A = 0;
    localparam int PRIO_B = 1;

    // Clear-engine state encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } init_state_t;

    // Number of byte lanes in a data word
    function automatic int nb_lanes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdp_ram_bw_if.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_bw_if
// Description : Bus bundle for tdp_ram_bw: both access ports, clear request
//               and status. master = requester side, slave = RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdp_ram_bw_if
    import dpram_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 16,
    parameter int N      = $clog2(DEPTH)
);
    localparam int NB = nb_lanes(WIDTH, BYTE_W);

    logic             init_req;
    logic             init_busy;
    logic             coll;

    logic             en_a;
    logic             we_a;
    logic [NB-1:0]    be_a;
    logic [N-1:0]     addr_a;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] dout_a;
    logic             dvalid_a;

    logic             en_b;
    logic             we_b;
    logic [NB-1:0]    be_b;
    logic [N-1:0]     addr_b;
    logic [WIDTH-1:0] din_b;
    logic [WIDTH-1:0] dout_b;
    logic             dvalid_b;

    modport master (
        output init_req,
        output en_a, we_a, be_a, addr_a, din_a,
        output en_b, we_b, be_b, addr_b, din_b,
        input  init_busy, coll,
        input  dout_a, dvalid_a,
        input  dout_b, dvalid_b
    );

    modport slave (
        input  init_req,
        input  en_a, we_a, be_a, addr_a, din_a,
        input  en_b, we_b, be_b, addr_b, din_b,
        output init_busy, coll,
        output dout_a, dvalid_a,
        output dout_b, dvalid_b
    );

endinterface
`default_nettype wire

// File: rtl/tdp_ram_bw_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_init_fsm
// Description : Sequential clear engine. Walks every word address once,
//               starting after reset release or on an init request in IDLE,
//               and reports busy while doing so.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_init_fsm
    import dpram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int N     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_req_i,
    output logic         init_busy_o,
    output logic         clr_we_o,
    output logic [N-1:0] clr_addr_o
);
    localparam logic [N-1:0] LAST_ADDR = N'(DEPTH - 1);

    init_state_t  state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;

    // State and counter registers; reset lands in CLEAR at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: CLEAR counts to the last word then idles; requests only start a clear from IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (init_req_i) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_busy_o = (state_q == ST_CLEAR);
    assign clr_we_o    = (state_q == ST_CLEAR);
    assign clr_addr_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tdp_ram_bw.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_bw
// Description : True dual-port RAM with per-byte write enables, selectable
//               same-port read-during-write, cross-port collision policy and
//               a sequential clear engine. Single clock domain.
//               Build option TDP_RAM_OUTREG_EN adds an output register stage
//               (read data, valid and collision flag arrive one cycle later).
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_bw
    import dpram_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BYTE_W    = 8,
    parameter int DEPTH     = 16,
    parameter int N         = $clog2(DEPTH),
    parameter int RDW_MODE  = RDW_READ_FIRST,
    parameter int COLL_PRIO = PRIO_A
) (
    input  logic        clk,
    input  logic        rst_n,
    tdp_ram_bw_if.slave bus
);
    localparam int NB = nb_lanes(WIDTH, BYTE_W);

    logic             init_busy;
    logic             clr_we;
    logic [N-1:0]     clr_addr;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             acc_a, acc_b;
    logic             inr_a, inr_b;
    logic             wr_a, wr_b;
    logic             same_wr;
    logic [WIDTH-1:0] bm_a, bm_b;
    logic [WIDTH-1:0] bm_a_eff, bm_b_eff;
    logic [WIDTH-1:0] old_a, old_b;
    logic [WIDTH-1:0] own_a, own_b;
    logic [WIDTH-1:0] dual_word;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             coll_d;

    logic [WIDTH-1:0] dout_a_q, dout_b_q;
    logic             dvalid_a_q, dvalid_b_q;
    logic             coll_q;

    tdp_ram_init_fsm #(
        .DEPTH (DEPTH),
        .N     (N)
    ) u_init_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req_i  (bus.init_req),
        .init_busy_o (init_busy),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign bus.init_busy = init_busy;

    // Ports are locked out entirely while the clear engine owns the array
    assign acc_a = bus.en_a & ~init_busy;
    assign acc_b = bus.en_b & ~init_busy;
    assign inr_a = 32'(bus.addr_a) < 32'(DEPTH);
    assign inr_b = 32'(bus.addr_b) < 32'(DEPTH);
    assign wr_a  = acc_a & bus.we_a & inr_a;
    assign wr_b  = acc_b & bus.we_b & inr_b;

    assign old_a = inr_a ? mem_q[bus.addr_a] : '0;
    assign old_b = inr_b ? mem_q[bus.addr_b] : '0;

    // Expand lane enables to bit masks; a port that is not writing contributes no lanes
    for (genvar k = 0; k < NB; k++) begin : g_lane_mask
        assign bm_a[k*BYTE_W +: BYTE_W] = {BYTE_W{wr_a & bus.be_a[k]}};
        assign bm_b[k*BYTE_W +: BYTE_W] = {BYTE_W{wr_b & bus.be_b[k]}};
    end

    // Each port's own write merged onto the stored word
    assign own_a = (old_a & ~bm_a) | (bus.din_a & bm_a);
    assign own_b = (old_b & ~bm_b) | (bus.din_b & bm_b);

    assign same_wr = wr_a & wr_b & (bus.addr_a == bus.addr_b);

    // On a same-word dual write the losing port gives up its overlapping lanes
    always_comb begin
        bm_a_eff = bm_a;
        bm_b_eff = bm_b;
        if (same_wr) begin
            if (COLL_PRIO == PRIO_A) begin
                bm_b_eff = bm_b & ~bm_a;
            end else begin
                bm_a_eff = bm_a & ~bm_b;
            end
        end
    end

    assign dual_word = (old_a & ~(bm_a_eff | bm_b_eff))
                     | (bus.din_a & bm_a_eff)
                     | (bus.din_b & bm_b_eff);

    // Array update: clear has exclusive use; a shared-word dual write is one combined store
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (same_wr) begin
            mem_q[bus.addr_a] <= dual_word;
        end else begin
            if (wr_a) begin
                mem_q[bus.addr_a] <= own_a;
            end
            if (wr_b) begin
                mem_q[bus.addr_b] <= own_b;
            end
        end
    end

    // Read data: the other port's write is never visible in the same cycle,
    // only this port's own write in write-first mode. Out-of-range reads return 0.
    if (RDW_MODE == RDW_WRITE_FIRST) begin : g_rdw_write_first
        assign rd_a = own_a;
        assign rd_b = own_b;
    end else begin : g_rdw_read_first
        assign rd_a = old_a;
        assign rd_b = old_b;
    end

    // A collision needs a shared address and at least one port actually storing lanes
    assign coll_d = acc_a & acc_b & (bus.addr_a == bus.addr_b)
                  & ((bus.we_a & (|bus.be_a)) | (bus.we_b & (|bus.be_b)));

    // First output stage: data holds between accesses, valid and collision are single-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            dvalid_a_q <= 1'b0;
            dvalid_b_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            dvalid_a_q <= acc_a;
            dvalid_b_q <= acc_b;
            coll_q     <= coll_d;
            if (acc_a) begin
                dout_a_q <= rd_a;
            end
            if (acc_b) begin
                dout_b_q <= rd_b;
            end
        end
    end

`ifdef TDP_RAM_OUTREG_EN
    logic [WIDTH-1:0] dout_a_r2_q, dout_b_r2_q;
    logic             dvalid_a_r2_q, dvalid_b_r2_q;
    logic             coll_r2_q;

    // Second output stage: straight one-cycle delay of the first stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_r2_q   <= '0;
            dout_b_r2_q   <= '0;
            dvalid_a_r2_q <= 1'b0;
            dvalid_b_r2_q <= 1'b0;
            coll_r2_q     <= 1'b0;
        end else begin
            dout_a_r2_q   <= dout_a_q;
            dout_b_r2_q   <= dout_b_q;
            dvalid_a_r2_q <= dvalid_a_q;
            dvalid_b_r2_q <= dvalid_b_q;
            coll_r2_q     <= coll_q;
        end
    end

    assign bus.dout_a   = dout_a_r2_q;
    assign bus.dout_b   = dout_b_r2_q;
    assign bus.dvalid_a = dvalid_a_r2_q;
    assign bus.dvalid_b = dvalid_b_r2_q;
    assign bus.coll     = coll_r2_q;
`else
    assign bus.dout_a   = dout_a_q;
    assign bus.dout_b   = dout_b_q;
    assign bus.dvalid_a = dvalid_a_q;
    assign bus.dvalid_b = dvalid_b_q;
    assign bus.coll     = coll_q;
`endif

endmodule
`default_nettype wire
